// File: rtl/resp_tol_checker.sv
// Response checker: compares a DUT beat stream against a golden ROM with +/-TOL wrap tolerance.
// Latency: beat accepted at edge t -> mask at t+2, err_cnt/first_err/chk_pulse after t+3.
// Backpressure: none; sustains one beat per cycle, bubbles on dut_valid are legal anywhere.
module resp_tol_checker #(
  parameter int W           = 16,
  parameter int LANES       = 16,
  parameter int COMPLEX     = 1,
  parameter int TOL         = 3,
  parameter int DEPTH       = 1024,
  parameter int FAIL_LIMIT  = 48,
  parameter int CHKPT_BEATS = 100,
  localparam int EW     = W * (1 + COMPLEX),
  localparam int NBEATS = DEPTH / LANES,
  localparam int AW     = (NBEATS > 1) ? $clog2(NBEATS) : 1,
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dut_valid,
  input  logic [LANES*EW-1:0] dut_data,
  output logic [AW-1:0]       gold_addr,
  input  logic [LANES*EW-1:0] gold_data,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail_abort,
  output logic [15:0]         err_cnt,
  output logic [IW-1:0]       first_err_idx,
  output logic                first_err_vld,
  output logic                chk_pulse,
  output logic                chk_ok
);

  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW  = $clog2(LANES + 1);
  localparam int CKW = (CHKPT_BEATS > 1) ? $clog2(CHKPT_BEATS) : 1;
  localparam logic [W-1:0] TOLV = W'(TOL);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ABORT} state_t;

  state_t               state;
  logic [AW-1:0]        beat_cnt;
  logic [CKW-1:0]       chk_cnt;

  logic                 s0_vld, s1_vld, s2_vld;
  logic [LANES*EW-1:0]  s0_dat, s1_dat, s1_gold;
  logic [AW-1:0]        s0_beat, s1_beat, s2_beat;
  logic [LANES-1:0]     s2_mask, mask_nxt;

  logic                 accept, last_beat, upd, abort_now, chk_hit, pipe_empty;
  logic [PW-1:0]        pop;
  logic [LW-1:0]        low;
  logic [16:0]          sum;
  logic [15:0]          err_nxt;

  assign gold_addr  = beat_cnt;
  assign busy       = (state == RUN) || (state == DRAIN);
  assign accept     = (state == RUN) && dut_valid;
  assign last_beat  = (beat_cnt == AW'(NBEATS - 1));
  assign pipe_empty = !s0_vld && !s1_vld && !s2_vld;

  // A component matches when the modular distance in either direction is within TOL.
  function automatic logic comp_ok(input logic [W-1:0] g, input logic [W-1:0] d);
    logic [W-1:0] fwd, bwd;
    fwd = g - d;
    bwd = d - g;
    return (fwd <= TOLV) || (bwd <= TOLV);
  endfunction

  // Per-lane mismatch mask from the aligned dut/golden pair.
  always_comb begin
    mask_nxt = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int c = 0; c < 1 + COMPLEX; c++) begin
        if (!comp_ok(s1_gold[l*EW + c*W +: W], s1_dat[l*EW + c*W +: W]))
          mask_nxt[l] = 1'b1;
      end
    end
  end

  // Popcount, lowest mismatching lane and the saturated error-count update.
  always_comb begin
    pop = '0;
    low = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (s2_mask[l]) begin
        pop = pop + PW'(1);
        low = LW'(l);
      end
    end
    sum       = {1'b0, err_cnt} + 17'(pop);
    err_nxt   = sum[16] ? 16'hFFFF : sum[15:0];
    upd       = s2_vld && busy;
    abort_now = upd && (err_nxt >= 16'(FAIL_LIMIT));
    chk_hit   = upd && (chk_cnt == CKW'(CHKPT_BEATS - 1));
  end

  // Three-stage datapath: capture beat, align with ROM output, register mask; flushed on abort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_vld  <= 1'b0;
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s0_dat  <= '0;
      s1_dat  <= '0;
      s1_gold <= '0;
      s0_beat <= '0;
      s1_beat <= '0;
      s2_beat <= '0;
      s2_mask <= '0;
    end else begin
      s0_vld <= accept && !abort_now;
      s1_vld <= s0_vld && busy && !abort_now;
      s2_vld <= s1_vld && busy && !abort_now;
      if (accept) begin
        s0_dat  <= dut_data;
        s0_beat <= beat_cnt;
      end
      if (s0_vld) begin
        s1_dat  <= s0_dat;
        s1_gold <= gold_data;
        s1_beat <= s0_beat;
      end
      if (s1_vld) begin
        s2_mask <= mask_nxt;
        s2_beat <= s1_beat;
      end
    end
  end

  // Run control FSM with registered result, checkpoint and first-error outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      chk_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_abort    <= 1'b0;
      chk_pulse     <= 1'b0;
      chk_ok        <= 1'b0;
    end else begin
      chk_pulse <= 1'b0;
      case (state)
        IDLE, DONE, ABORT: begin
          if (start) begin
            state         <= RUN;
            beat_cnt      <= '0;
            chk_cnt       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail_abort    <= 1'b0;
            chk_ok        <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          if (accept) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + AW'(1);
            if (last_beat) state <= DRAIN;
          end
          if (upd) begin
            err_cnt <= err_nxt;
            if ((s2_mask != '0) && !first_err_vld) begin
              first_err_idx <= IW'(s2_beat) * IW'(LANES) + IW'(low);
              first_err_vld <= 1'b1;
            end
            chk_cnt <= chk_hit ? '0 : chk_cnt + CKW'(1);
            if (chk_hit) begin
              chk_pulse <= 1'b1;
              chk_ok    <= (err_nxt == 16'd0);
            end
          end
          if (abort_now) begin
            state      <= ABORT;
            fail_abort <= 1'b1;
          end else if ((state == DRAIN) && pipe_empty) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (err_cnt == 16'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
